// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - parametrised synchronous FIFO with valid/ready handshakes
//
// Purpose: DEPTH x DATA_W register-array FIFO with show-ahead read data, a
// registered occupancy count, exact full/empty, programmable almost-full and
// almost-empty thresholds, and sticky overflow/underflow status.
// Optional embedded assertions are enabled by defining FIFO_SYNC_SVA_EN.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   clr          synchronous flush (pointers, count, sticky flags)
//   wr_valid     write request
//   wr_ready     write accept (= !full)
//   wr_data      write payload
//   rd_valid     read data available (= !empty)
//   rd_ready     read accept
//   rd_data      head entry, combinational from storage
//   count        occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   status
//   overflow     sticky, set by a write attempt while full
//   underflow    sticky, set by a read attempt while empty

module fifo_sync #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] ONE     = PW'(1);
  localparam logic [PW-1:0] AF_L    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L    = PW'(AE_LEVEL);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // MSB of each pointer is the wrap bit; the low AW bits address storage.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic wr_fire;
  logic rd_fire;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_ready = !full;
  assign rd_valid = !empty;

  assign wr_fire = wr_valid && wr_ready;
  assign rd_fire = rd_valid && rd_ready;

  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage has no reset; a write is dropped when rst or clr discards the fire.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst && !clr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + ONE;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (wr_valid && full) begin
        overflow <= 1'b1;
      end
      if (rd_ready && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_SYNC_SVA_EN
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= DEPTH_C);

  a_full_count: assert property (@(posedge clk) disable iff (rst)
    full == (count == DEPTH_C));

  a_empty_count: assert property (@(posedge clk) disable iff (rst)
    empty == (count == '0));

  a_no_wr_full: assert property (@(posedge clk) disable iff (rst)
    !(wr_fire && full));

  a_no_rd_empty: assert property (@(posedge clk) disable iff (rst)
    !(rd_fire && empty));

  // A flush legitimately changes the head, so it is excluded from stability.
  a_rd_stable: assert property (@(posedge clk) disable iff (rst)
    (rd_valid && !rd_ready && !clr) |=> $stable(rd_data));

  c_full:  cover property (@(posedge clk) disable iff (rst) full);
  c_empty: cover property (@(posedge clk) disable iff (rst) empty);
  c_both_near_full: cover property (@(posedge clk) disable iff (rst)
    wr_fire && rd_fire && (count == DEPTH_C - ONE));
`else
  // Assertions and covers are not elaborated in this build.
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - directed self-checking bench for fifo_sync

module tb_fifo_sync;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int checks;
  int errors;

  fifo_sync #(
    .DATA_W(8),
    .DEPTH(8),
    .AF_LEVEL(7),
    .AE_LEVEL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    clr      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rd_ready = 1'b0;

    // Reset then idle
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);

    // Fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      step();
      check("fill_count", 32'(count), 32'(i));
      check("fill_almost_full", 32'(almost_full), (i >= 7) ? 32'd1 : 32'd0);
      check("fill_almost_empty", 32'(almost_empty), (i <= 1) ? 32'd1 : 32'd0);
      check("fill_full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
    end

    // Overflow: write attempt while full is refused
    wr_data = 8'hFF;
    check("ovf_wr_ready", 32'(wr_ready), 32'd0);
    step();
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    wr_valid = 1'b0;
    step();
    check("ovf_held", 32'(overflow), 32'd1);
    check("ovf_count_held", 32'(count), 32'd8);

    // Drain: order preserved, 0xFF never appears
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_rd_valid", 32'(rd_valid), 32'd1);
      check("drain_rd_data", 32'(rd_data), 32'(i));
      step();
      check("drain_count", 32'(count), 32'(8 - i));
    end
    rd_ready = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ovf_still", 32'(overflow), 32'd1);

    // Flush with contents and a concurrent write
    wr_valid = 1'b1;
    wr_data  = 8'h21;
    step();
    wr_data  = 8'h22;
    step();
    check("pre_clr_count", 32'(count), 32'd2);
    clr     = 1'b1;
    wr_data = 8'h23;
    step();
    clr      = 1'b0;
    wr_valid = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_overflow", 32'(overflow), 32'd0);

    // Underflow
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_count", 32'(count), 32'd0);
    check("unf_empty", 32'(empty), 32'd1);
    step();
    check("unf_held", 32'(underflow), 32'd1);
    wr_valid = 1'b1;
    wr_data  = 8'h3C;
    step();
    wr_valid = 1'b0;
    check("unf_post_valid", 32'(rd_valid), 32'd1);
    check("unf_post_data", 32'(rd_data), 32'h3C);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("unf_post_empty", 32'(empty), 32'd1);

    // Simultaneous write/read at count 3 across pointer wrap
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'h10 + i);
      step();
    end
    check("sim_pre_count", 32'(count), 32'd3);
    rd_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_data = 8'(8'h13 + k);
      check("sim_rd_data", 32'(rd_data), 32'(8'h10 + k));
      step();
      check("sim_count", 32'(count), 32'd3);
    end
    wr_valid = 1'b0;
    for (int k = 20; k < 23; k++) begin
      check("sim_tail_data", 32'(rd_data), 32'(8'h10 + k));
      step();
    end
    rd_ready = 1'b0;
    check("sim_tail_empty", 32'(empty), 32'd1);

    // Reset mid-operation with a concurrent write
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h50 + i);
      step();
    end
    check("mid_pre_count", 32'(count), 32'd5);
    rst     = 1'b1;
    wr_data = 8'h77;
    step();
    rst      = 1'b0;
    wr_valid = 1'b0;
    check("mid_count", 32'(count), 32'd0);
    check("mid_empty", 32'(empty), 32'd1);
    check("mid_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_underflow", 32'(underflow), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    step();
    wr_valid = 1'b0;
    check("mid_first_valid", 32'(rd_valid), 32'd1);
    check("mid_first_data", 32'(rd_data), 32'hA5);
    check("mid_first_count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
